// File: rtl/addsub_pkg.sv
// addsub_pkg: shared op encoding and flag bundle
// for the pipelined add/subtract/compare unit.
package addsub_pkg;

  localparam logic [1:0] OP_SUB  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_RSUB = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b11;

  typedef struct packed {
    logic lt;
    logic eq;
    logic carry;
    logic overflow;
  } flags_t;

  localparam int FLAGS_W = $bits(flags_t);

endpackage

// File: rtl/addsub_core.sv
// addsub_core: combinational add/sub/compare with
// flag generation and optional saturation.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic [1:0]         op,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   left,
  input  logic [WIDTH-1:0]   right,
  output logic [WIDTH-1:0]   result,
  output logic [FLAGS_W-1:0] flags
);

  logic [WIDTH:0] wide;
  logic           ls;
  logic           rs;
  logic           ws;
  logic           ov_s;
  flags_t         f;

  assign ls = left[WIDTH-1];
  assign rs = right[WIDTH-1];
  assign ws = wide[WIDTH-1];

  // extended-width arithmetic; MSB is carry/borrow
  always_comb begin
    wide = {1'b0, left};
    ov_s = 1'b0;
    unique case (op)
      OP_ADD: begin
        wide = {1'b0, left} + {1'b0, right};
        ov_s = (ls == rs) && (ws != ls);
      end
      OP_SUB: begin
        wide = {1'b0, left} - {1'b0, right};
        ov_s = (ls != rs) && (ws != ls);
      end
      OP_RSUB: begin
        wide = {1'b0, right} - {1'b0, left};
        ov_s = (ls != rs) && (ws != rs);
      end
      default: begin
        wide = {1'b0, left};
        ov_s = 1'b0;
      end
    endcase
  end

  // flags and clamped result
  always_comb begin
    f.eq = (left == right);
    if (is_signed)
      f.lt = $signed(left) < $signed(right);
    else
      f.lt = left < right;
    f.carry    = (op != OP_CMP) && wide[WIDTH];
    f.overflow = 1'b0;
    if (op != OP_CMP)
      f.overflow = is_signed ? ov_s : f.carry;
    result = wide[WIDTH-1:0];
    if (SATURATE && f.overflow) begin
      if (!is_signed)
        result = (op == OP_ADD) ? '1 : '0;
      else if (ws)
        result = {1'b0, {(WIDTH-1){1'b1}}};
      else
        result = {1'b1, {(WIDTH-1){1'b0}}};
    end
    flags = f;
  end

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: two-stage valid/ready add/sub/cmp
// pipeline; stage 1 captures, stage 2 computes.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             lt,
  output logic             eq,
  output logic             carry,
  output logic             overflow
);

  logic             s1_valid;
  logic [1:0]       s1_op;
  logic             s1_signed;
  logic [WIDTH-1:0] s1_left;
  logic [WIDTH-1:0] s1_right;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  flags_t           s2_flags;

  logic             s1_adv;
  logic             s2_adv;

  logic [WIDTH-1:0]   core_result;
  logic [FLAGS_W-1:0] core_flags;

  // a stage advances when empty or its successor moves
  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv && !reset;
  end

  // stage 1: capture operands and controls
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_SUB;
      s1_signed <= 1'b0;
      s1_left   <= '0;
      s1_right  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op     <= op;
        s1_signed <= is_signed;
        s1_left   <= left;
        s1_right  <= right;
      end
    end
  end

  addsub_core #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_core (
    .op        (s1_op),
    .is_signed (s1_signed),
    .left      (s1_left),
    .right     (s1_right),
    .result    (core_result),
    .flags     (core_flags)
  );

  // stage 2: register result and flags, hold on stall
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= core_result;
        s2_flags  <= flags_t'(core_flags);
      end
    end
  end

  assign out_valid = s2_valid;
  assign result    = s2_result;
  assign lt        = s2_flags.lt;
  assign eq        = s2_flags.eq;
  assign carry     = s2_flags.carry;
  assign overflow  = s2_flags.overflow;

endmodule
